// File: rtl/mips_exec_pkg.sv
// Shared definitions for the 4-bit execution unit: opcodes, FSM states and the
// instruction word layout.
package mips_exec_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOR = 4'd5;
    localparam logic [3:0] OP_SLT = 4'd6;
    localparam logic [3:0] OP_SLL = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] rd1;
        logic [3:0] rd2;
        logic [3:0] wr;
    } instr_t;

    // Register-file read with R0 hardwired to zero.
    function automatic logic [3:0] rf_read(input logic [15:0][3:0] rf, input logic [3:0] addr);
        return (addr == 4'd0) ? 4'd0 : rf[addr];
    endfunction

endpackage

// File: rtl/mips_exec_if.sv
// Instruction handshake between the front-panel entry FSM (master) and the
// execution unit (slave).
interface mips_exec_if;
    logic [15:0] instruction;
    logic        start;
    logic        busy;
    logic        done;
    logic [3:0]  result;
    logic        overflow;

    modport master (output instruction, output start,
                    input busy, input done, input result, input overflow);
    modport slave  (input instruction, input start,
                    output busy, output done, output result, output overflow);
endinterface

// File: rtl/mips_exec_alu4.sv
// Combinational 4-bit ALU; we_ok says whether the result may be written back.
module mips_alu4
    import mips_exec_pkg::*;
(
    input  logic [3:0] op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] y,
    output logic       ovf,
    output logic       we_ok
);

    logic [3:0] y_s;
    logic       ovf_s;
    logic       valid_s;

    // Opcode decode and arithmetic; unknown opcodes behave as NOP.
    always_comb begin
        y_s     = 4'd0;
        ovf_s   = 1'b0;
        valid_s = 1'b1;
        case (op)
            OP_ADD: begin
                y_s   = a + b;
                ovf_s = (a[3] == b[3]) && (y_s[3] != a[3]);
            end
            OP_SUB: begin
                y_s   = a - b;
                ovf_s = (a[3] != b[3]) && (y_s[3] != a[3]);
            end
            OP_AND: y_s = a & b;
            OP_OR:  y_s = a | b;
            OP_XOR: y_s = a ^ b;
            OP_NOR: y_s = ~(a | b);
            OP_SLT: y_s = {3'b000, ($signed(a) < $signed(b))};
            OP_SLL: y_s = a << b[1:0];
            OP_SRL: y_s = a >> b[1:0];
            default: begin
                y_s     = 4'd0;
                ovf_s   = 1'b0;
                valid_s = 1'b0;
            end
        endcase
    end

    assign y     = y_s;
    assign ovf   = ovf_s;
    assign we_ok = valid_s & ~ovf_s;

endmodule

// File: rtl/mips_exec.sv
// Execution unit: latches an instruction, reads two registers, runs the ALU
// and writes the result back over a fixed four-state sequence.
module mips_exec
    import mips_exec_pkg::*;
#(
    parameter bit RESET_IDENT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    mips_exec_if.slave  bus,
    input  logic [3:0]  dbg_addr,
    output logic [3:0]  dbg_data
);

    state_e           state_q, state_d;
    instr_t           instr_q, instr_d;
    logic [3:0]       a_q, a_d, b_q, b_d;
    logic [3:0]       result_q, result_d;
    logic             ovf_q, ovf_d, we_q, we_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [15:0][3:0] rf_q, rf_d;
    logic [3:0]       alu_y_s;
    logic             alu_ovf_s, alu_we_s;

    function automatic logic [15:0][3:0] rf_init();
        logic [15:0][3:0] v;
        for (int i = 0; i < 16; i++) begin
            v[i] = RESET_IDENT ? 4'(i) : 4'd0;
        end
        return v;
    endfunction

    mips_alu4 u_alu (
        .op    (instr_q.op),
        .a     (a_q),
        .b     (b_q),
        .y     (alu_y_s),
        .ovf   (alu_ovf_s),
        .we_ok (alu_we_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a start pulse is only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_READ;
                else           state_d = ST_IDLE;
            end
            ST_READ: state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so busy/done come straight off flops.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_WB);
    end

    // Datapath next values for each step of the sequence.
    always_comb begin
        instr_d  = instr_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        we_d     = we_q;
        rf_d     = rf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) instr_d = instr_t'(bus.instruction);
                else           instr_d = instr_q;
            end
            ST_READ: begin
                a_d = rf_read(rf_q, instr_q.rd1);
                b_d = rf_read(rf_q, instr_q.rd2);
            end
            ST_EXEC: begin
                result_d = alu_y_s;
                ovf_d    = alu_ovf_s;
                we_d     = alu_we_s;
            end
            ST_WB: begin
                // R0 is never written, so it keeps its reset value of zero.
                if (we_q && (instr_q.wr != 4'd0)) rf_d[instr_q.wr] = result_q;
                else                              rf_d = rf_q;
            end
            default: rf_d = rf_q;
        endcase
    end

    // Datapath, register file and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q  <= '0;
            a_q      <= 4'd0;
            b_q      <= 4'd0;
            result_q <= 4'd0;
            ovf_q    <= 1'b0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rf_q     <= rf_init();
        end else begin
            instr_q  <= instr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            we_q     <= we_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rf_q     <= rf_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.overflow = ovf_q;
    assign dbg_data     = rf_read(rf_q, dbg_addr);

endmodule
